alu_share_arb: RTL and testbench

Two-requester round-robin arbiter and sequencer for one shared 32-bit ALU instance (add/sub/and/or, 2-bit Aluc, zero flag).
- Accepts an operation (X, Y, Aluc) from one requester at a time.
- Drives the ALU from registered operands and captures R/Z into a result register.
- Holds the result with a done flag until the owning requester acknowledges it.
- Sits between the decode/issue logic and the single ALU so that two issue sources, for example the main datapath and an address/branch-compare unit, can share it.

---
 rtl/alu_share_arb_pkg.sv | 29 ++
 rtl/alu_share_arb_rr_pick2.sv | 28 ++
 rtl/alu_share_arb.sv | 210 +++++++++++++++++++++
 tb/tb_alu_share_arb.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_arb_pkg.sv
// -----------------------------------------------------------------------------
// alu_share_arb_pkg
//   Shared constants for the ALU sharing arbiter:
//     - ALU op codes as the ALU decodes them (passed through unchanged).
//     - Arbiter FSM state encoding. The spare code 2'b11 is illegal and the
//       FSM steers it back to idle.
// -----------------------------------------------------------------------------
package alu_share_arb_pkg;

    typedef logic [1:0] aluc_t;
    typedef logic [1:0] arb_state_t;

    // ALU operation codes
    localparam aluc_t ALU_ADD = 2'b00;  // X + Y
    localparam aluc_t ALU_SUB = 2'b01;  // X - Y
    localparam aluc_t ALU_AND = 2'b10;  // X & Y
    localparam aluc_t ALU_OR  = 2'b11;  // X | Y

    // Arbiter FSM states
    localparam arb_state_t ST_IDLE = 2'b00;  // sampling requests
    localparam arb_state_t ST_BUSY = 2'b01;  // ALU computing on registered operands
    localparam arb_state_t ST_DONE = 2'b10;  // result held until the owner acknowledges

    // True for the three encodings the FSM is allowed to occupy.
    function automatic logic is_legal_state(input arb_state_t s);
        return (s == ST_IDLE) || (s == ST_BUSY) || (s == ST_DONE);
    endfunction

endpackage

// File: rtl/alu_share_arb_rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
//   Combinational two-way round-robin select.
//   Ports:
//     req0, req1 : request levels
//     prio       : index that wins when both request
//     valid      : at least one request present
//     sel        : index of the selected requester (only meaningful if valid)
// -----------------------------------------------------------------------------
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic prio,
    output logic valid,
    output logic sel
);

    always_comb begin
        valid = req0 | req1;
        // A lone request always wins; a tie goes to the priority index.
        if (req0 && req1) begin
            sel = prio;
        end else begin
            sel = req1;
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// -----------------------------------------------------------------------------
// alu_share_arb
//   Round-robin arbiter/sequencer letting two issue sources share one ALU.
//   One operation is in flight at a time: IDLE picks a requester and
//   registers its operands onto the ALU inputs, BUSY gives the ALU one cycle
//   of stable inputs and captures R/Z, DONE holds the result until the owner
//   acknowledges it. The priority flips to the other requester after every
//   completed operation, so continuous contention alternates strictly.
//
//   Ports:
//     Clk, Clrn          : clock, asynchronous active-low reset
//     req*/x*/y*/aluc*   : per-requester operation (level request)
//     gnt*               : one-cycle pulse, operands of that requester latched
//     done*              : result valid for that requester, held until rack*
//     rack*              : requester accepts its result (owner only)
//     res, zero, owner   : registered result, zero flag, index being served
//     alu_x/alu_y/alu_aluc, alu_r/alu_z : connection to the shared ALU
// -----------------------------------------------------------------------------
module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Clrn,

    input  logic             req0,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] y0,
    input  logic [1:0]       aluc0,

    input  logic             req1,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] y1,
    input  logic [1:0]       aluc1,

    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    input  logic             rack0,
    input  logic             rack1,

    output logic [WIDTH-1:0] res,
    output logic             zero,
    output logic             owner,

    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic [1:0]       alu_aluc,
    input  logic [WIDTH-1:0] alu_r,
    input  logic             alu_z
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    arb_state_t       state_q,    state_d;
    logic             prio_q,     prio_d;
    logic             owner_q,    owner_d;
    logic             gnt0_q,     gnt0_d;
    logic             gnt1_q,     gnt1_d;
    logic             done0_q,    done0_d;
    logic             done1_q,    done1_d;
    logic [WIDTH-1:0] res_q,      res_d;
    logic             zero_q,     zero_d;
    logic [WIDTH-1:0] alu_x_q,    alu_x_d;
    logic [WIDTH-1:0] alu_y_q,    alu_y_d;
    logic [1:0]       alu_aluc_q, alu_aluc_d;

    // -------------------------------------------------------------------------
    // Request selection
    // -------------------------------------------------------------------------
    logic pick_valid;
    logic pick_sel;

    rr_pick2 u_pick (
        .req0  (req0),
        .req1  (req1),
        .prio  (prio_q),
        .valid (pick_valid),
        .sel   (pick_sel)
    );

    // Only the current owner's acknowledge can retire the operation.
    logic owner_rack;
    assign owner_rack = owner_q ? rack1 : rack0;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        state_d    = state_q;
        prio_d     = prio_q;
        owner_d    = owner_q;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        done0_d    = done0_q;
        done1_d    = done1_q;
        res_d      = res_q;
        zero_d     = zero_q;
        alu_x_d    = alu_x_q;
        alu_y_d    = alu_y_q;
        alu_aluc_d = alu_aluc_q;

        case (state_q)
            ST_IDLE: begin
                // With no request the ALU input registers keep their value.
                if (pick_valid) begin
                    owner_d    = pick_sel;
                    alu_x_d    = pick_sel ? x1    : x0;
                    alu_y_d    = pick_sel ? y1    : y0;
                    alu_aluc_d = pick_sel ? aluc1 : aluc0;
                    gnt0_d     = ~pick_sel;
                    gnt1_d     = pick_sel;
                    state_d    = ST_BUSY;
                end
            end

            ST_BUSY: begin
                // ALU inputs have been stable for a full cycle; capture.
                res_d   = alu_r;
                zero_d  = alu_z;
                done0_d = ~owner_q;
                done1_d = owner_q;
                state_d = ST_DONE;
            end

            ST_DONE: begin
                if (owner_rack) begin
                    done0_d = 1'b0;
                    done1_d = 1'b0;
                    prio_d  = ~owner_q;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                // Illegal encoding: drop anything pending and resume sampling.
                done0_d = 1'b0;
                done1_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: every register here, including the datapath ones, is reset so the
    // outputs are defined zeros while Clrn is low.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            state_q    <= ST_IDLE;
            prio_q     <= 1'b0;
            owner_q    <= 1'b0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            res_q      <= '0;
            zero_q     <= 1'b0;
            alu_x_q    <= '0;
            alu_y_q    <= '0;
            alu_aluc_q <= 2'b00;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q    <= state_d;
            prio_q     <= prio_d;
            owner_q    <= owner_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            res_q      <= res_d;
            zero_q     <= zero_d;
            alu_x_q    <= alu_x_d;
            alu_y_q    <= alu_y_d;
            alu_aluc_q <= alu_aluc_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign done0    = done0_q;
    assign done1    = done1_q;
    assign res      = res_q;
    assign zero     = zero_q;
    assign owner    = owner_q;
    assign alu_x    = alu_x_q;
    assign alu_y    = alu_y_q;
    assign alu_aluc = alu_aluc_q;

    // -------------------------------------------------------------------------
    // Invariants
    // -------------------------------------------------------------------------
    a_gnt_onehot : assert property (@(posedge Clk) disable iff (!Clrn)
        !(gnt0_q && gnt1_q));
    a_done_onehot : assert property (@(posedge Clk) disable iff (!Clrn)
        !(done0_q && done1_q));
    a_state_legal : assert property (@(posedge Clk) disable iff (!Clrn)
        is_legal_state(state_q));

endmodule

// File: tb/tb_alu_share_arb.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arb
//   Self-checking bench for alu_share_arb. A behavioural ALU sits on the
//   alu_* ports. Expected values come from a transaction-level model: the
//   winner is derived from the request levels and a priority bit that flips
//   to the other requester after each retired operation, and the result is
//   computed directly from the operands with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_alu_share_arb;
    import alu_share_arb_pkg::*;

    localparam int W = 32;

    logic         Clk;
    logic         Clrn;
    logic         req0, req1;
    logic [W-1:0] x0, y0, x1, y1;
    logic [1:0]   aluc0, aluc1;
    logic         gnt0, gnt1, done0, done1;
    logic         rack0, rack1;
    logic [W-1:0] res;
    logic         zero;
    logic         owner;
    logic [W-1:0] alu_x, alu_y, alu_r;
    logic [1:0]   alu_aluc;
    logic         alu_z;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: which requester wins a tie at the next arbitration.
    int m_prio = 0;

    alu_share_arb #(.WIDTH(W)) dut (
        .Clk      (Clk),
        .Clrn     (Clrn),
        .req0     (req0),
        .x0       (x0),
        .y0       (y0),
        .aluc0    (aluc0),
        .req1     (req1),
        .x1       (x1),
        .y1       (y1),
        .aluc1    (aluc1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .done0    (done0),
        .done1    (done1),
        .rack0    (rack0),
        .rack1    (rack1),
        .res      (res),
        .zero     (zero),
        .owner    (owner),
        .alu_x    (alu_x),
        .alu_y    (alu_y),
        .alu_aluc (alu_aluc),
        .alu_r    (alu_r),
        .alu_z    (alu_z)
    );

    // Shared ALU
    always_comb begin
        case (alu_aluc)
            ALU_ADD: alu_r = alu_x + alu_y;
            ALU_SUB: alu_r = alu_x - alu_y;
            ALU_AND: alu_r = alu_x & alu_y;
            default: alu_r = alu_x | alu_y;
        endcase
        alu_z = (alu_r == '0);
    end

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] b(input logic v);
        return {{(W-1){1'b0}}, v};
    endfunction

    function automatic logic [W-1:0] ref_alu(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic [1:0] op);
        longint unsigned s;
        case (op)
            2'd0: s = longint'(x) + longint'(y);
            2'd1: s = longint'(x) + (64'h1_0000_0000 - longint'(y));
            2'd2: return x & y;
            default: return x | y;
        endcase
        return s[W-1:0];
    endfunction

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Clrn = 1'b0;
        step();
        step();
        Clrn = 1'b1;
        m_prio = 0;
    endtask

    // One full operation starting from IDLE with the current request levels.
    //   hold : cycles the owner delays its acknowledge
    //   poke : during the hold, the non-owner pulses rack and raises req
    //   drop : owner drops its request right after its grant
    task automatic txn(input int hold, input bit poke, input bit drop, output int w);
        logic [W-1:0] ex, ey, er;
        logic [1:0]   ec;
        logic         ez;
        w  = (req0 && req1) ? m_prio : (req1 ? 1 : 0);
        ex = (w == 1) ? x1 : x0;
        ey = (w == 1) ? y1 : y0;
        ec = (w == 1) ? aluc1 : aluc0;
        er = ref_alu(ex, ey, ec);
        ez = (er == '0);

        step();  // arbitration edge: BUSY cycle
        check("gnt0", b(gnt0), b(w == 0));
        check("gnt1", b(gnt1), b(w == 1));
        check("owner", b(owner), b(w == 1));
        check("alu_x", alu_x, ex);
        check("alu_y", alu_y, ey);
        check("alu_aluc", {30'b0, alu_aluc}, {30'b0, ec});
        check("busy_done", b(done0 | done1), '0);
        if (drop) begin
            if (w == 1) req1 = 1'b0; else req0 = 1'b0;
        end

        step();  // first DONE cycle
        check("done_gnt", b(gnt0 | gnt1), '0);
        check("done0", b(done0), b(w == 0));
        check("done1", b(done1), b(w == 1));
        check("res", res, er);
        check("zero", b(zero), b(ez));

        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                if (w == 1) begin rack0 = 1'b1; req0 = 1'b1; end
                else        begin rack1 = 1'b1; req1 = 1'b1; end
            end
            step();
            rack0 = 1'b0;
            rack1 = 1'b0;
            check("hold_done", b(w == 1 ? done1 : done0), 32'd1);
            check("hold_other", b(w == 1 ? done0 : done1), '0);
            check("hold_res", res, er);
            check("hold_gnt", b(gnt0 | gnt1), '0);
        end

        if (w == 1) rack1 = 1'b1; else rack0 = 1'b1;
        step();  // back in IDLE
        rack0 = 1'b0;
        rack1 = 1'b0;
        check("ack_done", b(done0 | done1), '0);
        check("ack_gnt", b(gnt0 | gnt1), '0);
        check("ack_res", res, er);
        m_prio = (w == 0) ? 1 : 0;
    endtask

    // Output exclusivity, every cycle
    always @(negedge Clk) begin
        check("gnt_excl", b(gnt0 & gnt1), '0);
        check("done_excl", b(done0 & done1), '0);
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        int w;
        Clrn  = 1'b0;
        req0  = 1'b0; req1  = 1'b0;
        x0    = '0;   y0    = '0;   aluc0 = 2'b00;
        x1    = '0;   y1    = '0;   aluc1 = 2'b00;
        rack0 = 1'b0; rack1 = 1'b0;

        // 1: reset with a pending request, then release idle
        req0 = 1'b1; x0 = 32'd11; y0 = 32'd22;
        #1;
        for (int c = 0; c < 2; c++) begin
            check("rst_gnt", b(gnt0 | gnt1), '0);
            check("rst_done", b(done0 | done1), '0);
            check("rst_res", res, '0);
            check("rst_zero", b(zero), '0);
            check("rst_owner", b(owner), '0);
            check("rst_alu_x", alu_x, '0);
            check("rst_alu_y", alu_y, '0);
            check("rst_aluc", {30'b0, alu_aluc}, '0);
            step();
        end
        req0 = 1'b0;
        Clrn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check("idle_alu_x", alu_x, '0);
            check("idle_gnt", b(gnt0 | gnt1), '0);
        end

        // 2: single subtract 5-3
        req0 = 1'b1; x0 = 32'd5; y0 = 32'd3; aluc0 = ALU_SUB;
        txn(0, 1'b0, 1'b1, w);

        // 3: simultaneous add and zero-result subtract after reset
        do_reset();
        x0 = 32'd7; y0 = 32'd9; aluc0 = ALU_ADD;
        x1 = 32'd4; y1 = 32'd4; aluc1 = ALU_SUB;
        req0 = 1'b1; req1 = 1'b1;
        txn(0, 1'b0, 1'b1, w);
        txn(0, 1'b0, 1'b1, w);

        // 4: continuous contention alternates
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 4; k++) txn(0, 1'b0, 1'b0, w);
        req0 = 1'b0; req1 = 1'b0;
        step();

        // 5: owner holds its ack; non-owner ack is ignored
        x0 = 32'hF0F0_F0F0; y0 = 32'h0FF0_FF00; aluc0 = ALU_AND;
        x1 = 32'h1234_0000; y1 = 32'h0000_5678; aluc1 = ALU_OR;
        req0 = 1'b1;
        txn(5, 1'b1, 1'b1, w);
        txn(0, 1'b0, 1'b1, w);  // requester 1 raised during the hold

        // 6: reset during BUSY drops the operation
        req1 = 1'b1; x1 = 32'h00FF_0000; y1 = 32'h0000_00FF; aluc1 = ALU_OR;
        step();
        check("t6_gnt1", b(gnt1), 32'd1);
        Clrn = 1'b0;
        #1;
        check("t6_rst_gnt", b(gnt0 | gnt1), '0);
        check("t6_rst_alu_x", alu_x, '0);
        for (int c = 0; c < 2; c++) begin
            step();
            check("t6_done1", b(done1), '0);
            check("t6_res", res, '0);
        end
        x0 = 32'd100; y0 = 32'd1; aluc0 = ALU_SUB;
        req0 = 1'b1; req1 = 1'b1;
        m_prio = 0;
        Clrn = 1'b1;
        txn(0, 1'b0, 1'b1, w);
        txn(0, 1'b0, 1'b1, w);

        // Randomized traffic
        for (int t = 0; t < 80; t++) begin
            if (!req0) begin
                x0 = rnd_operand();
                y0 = ($urandom_range(0, 3) == 0) ? x0 : rnd_operand();
                aluc0 = 2'($urandom_range(0, 3));
                req0 = ($urandom_range(0, 2) != 0);
            end
            if (!req1) begin
                x1 = rnd_operand();
                y1 = ($urandom_range(0, 3) == 0) ? x1 : rnd_operand();
                aluc1 = 2'($urandom_range(0, 3));
                req1 = ($urandom_range(0, 2) != 0);
            end
            if (!req0 && !req1) req0 = 1'b1;
            txn($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b1, w);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
